// File: rtl/multi_button_debouncer.sv
// multi_button_debouncer
//   N_CH-channel push-button debouncer. Each channel has a 2-flop
//   synchroniser. A press is qualified after DOWN_CYCLES stable-high
//   synchronised samples, and a release after UP_CYCLES stable-low samples.
//   Any sample equal to the current level restarts qualification.
//
// Optional feature: define MULTI_BUTTON_DEBOUNCER_LONG_PRESS_EN to add a
//   per-channel hold counter. That counter fires one long_press strobe
//   HOLD_CYCLES cycles into a qualified press.
//
// Ports
//   clk              : clock, all logic on posedge
//   rst              : synchronous active-high reset
//   button           : raw asynchronous button levels (active-high)
//   debounced_button : qualified level per channel
//   pressed          : one-cycle strobe on a qualified 0->1
//   released         : one-cycle strobe on a qualified 1->0
//   long_press       : one-cycle strobe after HOLD_CYCLES of press
//                      (constant 0 without the macro)

module multi_button_debouncer #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DOWN_CYCLES = 5000000,
  parameter int unsigned UP_CYCLES   = 10000,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] debounced_button,
  output logic [N_CH-1:0] pressed,
  output logic [N_CH-1:0] released,
  output logic [N_CH-1:0] long_press
);

  if (N_CH == 0 || DOWN_CYCLES == 0 || UP_CYCLES == 0 || HOLD_CYCLES == 0) begin : g_bad_cfg
    $error("multi_button_debouncer: N_CH and all cycle counts must be >= 1");
  end

  localparam logic [CNT_W-1:0] DOWN_LAST = CNT_W'(DOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] UP_LAST   = CNT_W'(UP_CYCLES - 1);

  logic [N_CH-1:0]            s1_q, s1_d;
  logic [N_CH-1:0]            s2_q, s2_d;
  logic [N_CH-1:0]            deb_q, deb_d;
  logic [N_CH-1:0]            pressed_q, pressed_d;
  logic [N_CH-1:0]            released_q, released_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d       = button;
    s2_d       = s1_q;
    deb_d      = deb_q;
    pressed_d  = '0;
    released_d = '0;
    cnt_d      = cnt_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == (deb_q[i] ? UP_LAST : DOWN_LAST)) begin
        // Toggle and clear together, so the next threshold starts from zero.
        deb_d[i]      = ~deb_q[i];
        cnt_d[i]      = '0;
        pressed_d[i]  = ~deb_q[i];
        released_d[i] = deb_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      pressed_q  <= '0;
      released_q <= '0;
      cnt_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_q      <= deb_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      cnt_q      <= cnt_d;
    end
  end

  assign debounced_button = deb_q;
  assign pressed          = pressed_q;
  assign released         = released_q;

`ifdef MULTI_BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic [N_CH-1:0][CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_CH-1:0]            hold_done_q, hold_done_d;
  logic [N_CH-1:0]            long_press_q, long_press_d;

  // hold_cnt parks at HOLD_LAST; hold_done keeps that parked value from
  // re-firing the strobe on every later cycle of the same press.
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    hold_done_d  = hold_done_q;
    long_press_d = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!deb_q[i]) begin
        hold_cnt_d[i]  = '0;
        hold_done_d[i] = 1'b0;
      end else if (!hold_done_q[i]) begin
        if (hold_cnt_q[i] == HOLD_LAST) begin
          long_press_d[i] = 1'b1;
          hold_done_d[i]  = 1'b1;
        end else begin
          hold_cnt_d[i] = hold_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q   <= '0;
      hold_done_q  <= '0;
      long_press_q <= '0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      hold_done_q  <= hold_done_d;
      long_press_q <= long_press_d;
    end
  end

  assign long_press = long_press_q;
`else
  assign long_press = '0;
`endif

endmodule
